ks_audio_out: RTL and testbench
===============================

// Module: ks_audio_out
// PURPOSE
//   Output stage directly downstream of the Karplus-Strong string voice. Takes the signed
//   per-clock voice sample, applies a click-free soft mute / volume gain ramp, and drives a
//   1-bit first-order sigma-delta (PDM) stream for an external RC filter. Also exposes the
//   gain-scaled parallel sample for monitoring.
// PARAMETERS
//   DATA_WIDTH  8   sample width, signed two's complement
//   GAIN_BITS   8   gain/volume width; gain = value / 2^GAIN_BITS (max (2^GAIN_BITS-1)/2^GAIN_BITS)
//   RAMP_DIV    16  clocks per gain step while ramping (>=1)
// PORTS
//   clk_i     in   1           clock
//   rst_ni    in   1           synchronous reset, active low
//   sample_i  in   DATA_WIDTH  signed voice sample, valid every clock
//   enable_i  in   1           1 = play at volume_i, 0 = soft mute
//   volume_i  in   GAIN_BITS   target gain when enabled (unsigned)
//   sample_o  out  DATA_WIDTH  signed gain-scaled sample (registered)
//   pdm_o     out  1           sigma-delta bitstream (registered)
//   muted_o   out  1           1 while FSM in MUTED
//   busy_o    out  1           1 while FSM in RAMP
// BEHAVIOUR
//   Reset (rst_ni=0 at posedge): sample_q, scaled_q, acc, gain_q, div_cnt = 0; FSM=MUTED;
//     sample_o=0, pdm_o=0, muted_o=1, busy_o=0. Reset mid-ramp aborts ramp; takes effect next edge.
//   Pipeline: sample_q <= sample_i; scaled_q <= scale(sample_q, gain_q); sample_o = scaled_q.
//     sample_i -> sample_o latency 2 clocks; sample_i -> pdm_o bit 3 clocks.
//   Target: tgt = enable_i ? volume_i : 0, evaluated combinationally every clock.
//   Gain FSM (gain_q is GAIN_BITS wide, unsigned):
//     MUTED: gain_q=0. tgt!=0 -> RAMP, div_cnt<=0.
//     RAMP : div_cnt counts 0..RAMP_DIV-1; at RAMP_DIV-1 gain_q steps +/-1 toward current tgt
//            and div_cnt wraps to 0. Direction re-evaluated at every step (tgt may change
//            mid-ramp). When gain_q==tgt after a step (or on entry check): tgt==0 -> MUTED,
//            else -> HOLD. gain_q never overshoots tgt, never wraps.
//     HOLD : gain_q constant. tgt!=gain_q -> RAMP, div_cnt<=0.
//     Simultaneous tgt change and step: step uses the tgt present in that clock.
//   Scale: prod = signed(sample_q) * signed({1'b0,gain_q}), width DATA_WIDTH+GAIN_BITS+1;
//     scaled = prod >>> GAIN_BITS (arithmetic, floor), truncated to DATA_WIDTH. Since gain<1,
//     no overflow possible; no saturation logic needed.
//   Sigma-delta: u = {~scaled_q[MSB], scaled_q[MSB-1:0]} (offset binary, 0..2^DATA_WIDTH-1).
//     acc is DATA_WIDTH+1 bits: acc <= {1'b0, acc[DATA_WIDTH-1:0]} + u; pdm_o <= carry of that sum.
//     Ones density = u / 2^DATA_WIDTH. Muted (scaled=0, u=0x80 for 8b) gives 50% density.
//   Boundaries: u=0 -> pdm_o constant 0; u max -> one 0 per 2^DATA_WIDTH clocks.
//     volume_i=0 with enable_i=1 behaves as mute (ramps to MUTED).
//   All outputs driven from registers except muted_o/busy_o, which decode registered FSM state.
// TESTING (DATA_WIDTH=8, GAIN_BITS=8, RAMP_DIV=4 unless stated)
//   1. Reset, enable_i=0, sample_i=0x7F for 64 clocks -> sample_o=0x00, muted_o=1,
//      pdm_o alternates 0/1 (32 ones in any 64-clock window after clock 3), busy_o=0.
//   2. enable_i=1, volume_i=0xFF from MUTED -> busy_o=1 for 255*4 clocks, gain_q=0xFF,
//      then HOLD; sample_i=0x7F -> sample_o=0x7E; sample_i=0x80 -> sample_o=0x80, pdm_o stuck 0.
//   3. HOLD at 0xFF, sample_i=0x40 -> sample_o=0x3F, u=0xBF: 191 ones per 256 clocks (+/-1).
//   4. Ramp up to 0xFF; when gain_q=100 set volume_i=40 -> gain_q decrements each 4 clocks,
//      settles 40 in HOLD, never below 40, busy_o drops on the settling step.
//   5. HOLD at 0x80, drop enable_i -> gain reaches 0 after 128*4 clocks, FSM MUTED, muted_o=1,
//      sample_o=0; re-assert enable_i same clock muted_o rises -> RAMP next clock.
//   6. Assert rst_ni=0 for 1 clock mid-ramp (gain_q=57) -> next clock all outputs at reset
//      values, gain_q=0, MUTED; with enable_i still 1, ramp restarts from 0.

Source files
------------

// File: rtl/ks_audio_out.sv
// ks_audio_out: output stage for the Karplus-Strong voice.
// Applies a click-free gain ramp (soft mute / volume) to the per-clock voice
// sample. Drives a first-order sigma-delta bitstream for an external RC filter.
// The gain-scaled parallel sample is also brought out for monitoring.
//
// Handshake: there is none. sample_i is valid on every clock, and sample_o and
// pdm_o are valid on every clock after reset. sample_i reaches sample_o after
// 2 clocks, and the matching pdm_o bit appears after 3 clocks.
module ks_audio_out #(
    parameter int DATA_WIDTH = 8,
    parameter int GAIN_BITS  = 8,
    parameter int RAMP_DIV   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  enable_i,
    input  logic [GAIN_BITS-1:0]  volume_i,
    output logic [DATA_WIDTH-1:0] sample_o,
    output logic                  pdm_o,
    output logic                  muted_o,
    output logic                  busy_o
);

    localparam int PROD_W = DATA_WIDTH + GAIN_BITS + 1;
    localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        MUTED = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state;
    logic [GAIN_BITS-1:0]    gain_q;
    logic [DIV_W-1:0]        div_cnt;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic [DATA_WIDTH-1:0]   scaled_q;
    // The sigma-delta accumulator is {pdm_q, acc}. Its top bit is the
    // carry, which is exactly the output bit.
    logic [DATA_WIDTH-1:0]   acc;
    logic                    pdm_q;

    logic [GAIN_BITS-1:0]    tgt;
    logic [GAIN_BITS-1:0]    gain_next;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_WIDTH-1:0]   u;
    logic [DATA_WIDTH:0]     sum;

    // Target gain and one ramp step toward it.
    always_comb begin
        tgt       = enable_i ? volume_i : '0;
        gain_next = (gain_q < tgt) ? gain_q + 1'b1 : gain_q - 1'b1;
    end

    // Signed multiply by an unsigned fraction. The shift floors the result,
    // and since gain < 1 the low DATA_WIDTH bits cannot overflow.
    always_comb begin
        prod = $signed(sample_q) * $signed({1'b0, gain_q});
        u    = {~scaled_q[DATA_WIDTH-1], scaled_q[DATA_WIDTH-2:0]};
        sum  = {1'b0, acc} + {1'b0, u};
    end

    // Gain FSM: ramp gain_q one step every RAMP_DIV clocks toward the target.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= MUTED;
            gain_q  <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                MUTED: begin
                    gain_q  <= '0;
                    div_cnt <= '0;
                    if (tgt != '0) state <= RAMP;
                end
                RAMP: begin
                    if (gain_q == tgt) begin
                        // The target moved onto the current gain: settle without stepping.
                        div_cnt <= '0;
                        state   <= (tgt == '0) ? MUTED : HOLD;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        gain_q  <= gain_next;
                        if (gain_next == tgt) state <= (tgt == '0) ? MUTED : HOLD;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (tgt != gain_q) begin
                        state   <= RAMP;
                        div_cnt <= '0;
                    end
                end
                default: begin
                    state   <= MUTED;
                    gain_q  <= '0;
                    div_cnt <= '0;
                end
            endcase
        end
    end

    // Sample pipeline, gain scaling and sigma-delta modulator.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sample_q <= '0;
            scaled_q <= '0;
            acc      <= '0;
            pdm_q    <= 1'b0;
        end else begin
            sample_q <= sample_i;
            scaled_q <= DATA_WIDTH'(prod >>> GAIN_BITS);
            acc      <= sum[DATA_WIDTH-1:0];
            pdm_q    <= sum[DATA_WIDTH];
        end
    end

    assign sample_o = scaled_q;
    assign pdm_o    = pdm_q;
    assign muted_o  = (state == MUTED);
    assign busy_o   = (state == RAMP);

endmodule

// File: tb/tb_ks_audio_out.sv
// Testbench for ks_audio_out (8-bit samples, 8-bit gain, RAMP_DIV=4).
// The stimulus thread pushes time-tagged expectations into a queue.
// A negedge monitor pops each entry when it falls due and compares it.
module tb_ks_audio_out;

    localparam int K_SAMPLE = 0;
    localparam int K_MUTED  = 1;
    localparam int K_BUSY   = 2;
    localparam int K_PDM    = 3;
    localparam int K_GAIN   = 4;
    localparam int K_WEXACT = 5;
    localparam int K_WCLR   = 6;
    localparam int K_WNEAR  = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] sample_in;
    logic [7:0] volume;
    logic [7:0] sample_out;
    logic       pdm;
    logic       muted;
    logic       busy;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int win_cnt = 0;

    logic [15:0] exp_q[$];
    int          due_q[$];
    int          kind_q[$];

    ks_audio_out #(.DATA_WIDTH(8), .GAIN_BITS(8), .RAMP_DIV(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .sample_i(sample_in),
        .enable_i(enable),
        .volume_i(volume),
        .sample_o(sample_out),
        .pdm_o   (pdm),
        .muted_o (muted),
        .busy_o  (busy)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int kind, input int dly, input logic [15:0] v);
        due_q.push_back(cyc + dly);
        kind_q.push_back(kind);
        exp_q.push_back(v);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        volume = 8'h00;
        tick(1);
        rst_n  = 1'b1;
    endtask

    task automatic drain();
        int budget;
        budget = 5000;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    // scoreboard monitor
    initial begin
        int          d;
        int          k;
        logic [15:0] e;
        logic [15:0] act;
        bit          bad;
        string       name;
        forever begin
            @(negedge clk);
            if (pdm) win_cnt = win_cnt + 1;
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                d = due_q.pop_front();
                k = kind_q.pop_front();
                e = exp_q.pop_front();
                if (k == K_WCLR) begin
                    win_cnt = 0;
                end else begin
                    case (k)
                        K_SAMPLE: begin act = {8'h00, sample_out}; name = "sample_o"; end
                        K_MUTED:  begin act = {15'h0, muted};      name = "muted_o";  end
                        K_BUSY:   begin act = {15'h0, busy};       name = "busy_o";   end
                        K_PDM:    begin act = {15'h0, pdm};        name = "pdm_o";    end
                        K_GAIN:   begin act = {8'h00, dut.gain_q}; name = "gain_q";   end
                        default:  begin act = 16'(win_cnt);        name = "pdm_ones"; end
                    endcase
                    if (k == K_WNEAR)
                        bad = (act > e + 16'd1) || (act + 16'd1 < e);
                    else
                        bad = (act != e) || (d != cyc);
                    vectors++;
                    if (bad) begin
                        miscompares++;
                        $display("FAIL %s cyc=%0d due=%0d got=%0h want=%0h", name, cyc, d, act, e);
                    end
                end
            end
        end
    end

    // directed stimulus
    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        volume    = 8'h00;
        sample_in = 8'h7F;
        tick(1);
        push_exp(K_SAMPLE, 0, 16'h00);
        push_exp(K_PDM,    0, 16'h0);
        push_exp(K_MUTED,  0, 16'h1);
        push_exp(K_BUSY,   0, 16'h0);
        push_exp(K_GAIN,   0, 16'h00);
        tick(1);
        rst_n = 1'b1;

        // 1: muted, 50% density
        tick(8);
        push_exp(K_SAMPLE, 0, 16'h00);
        push_exp(K_MUTED,  0, 16'h1);
        push_exp(K_BUSY,   0, 16'h0);
        push_exp(K_WCLR,   1, 16'h0);
        push_exp(K_WEXACT, 65, 16'd32);
        drain();

        // 2: full ramp up to 0xFF
        enable = 1'b1;
        volume = 8'hFF;
        push_exp(K_BUSY, 1,    16'h1);
        push_exp(K_GAIN, 4,    16'h00);
        push_exp(K_GAIN, 5,    16'h01);
        push_exp(K_BUSY, 1020, 16'h1);
        push_exp(K_BUSY, 1021, 16'h0);
        push_exp(K_GAIN, 1021, 16'hFF);
        push_exp(K_MUTED, 1021, 16'h0);
        tick(1021);
        sample_in = 8'h7F;
        push_exp(K_SAMPLE, 2, 16'h7E);
        tick(4);
        sample_in = 8'h80;
        push_exp(K_SAMPLE, 2, 16'h80);
        push_exp(K_WCLR,   2, 16'h0);
        push_exp(K_WEXACT, 34, 16'd0);
        drain();

        // 3: 0x40 at full gain
        sample_in = 8'h40;
        push_exp(K_SAMPLE, 2, 16'h3F);
        push_exp(K_WCLR,   3, 16'h0);
        push_exp(K_WNEAR,  259, 16'd191);
        drain();

        // 4: retarget mid-ramp from 100 down to 40
        do_reset();
        enable = 1'b1;
        volume = 8'hFF;
        push_exp(K_GAIN, 401, 16'd100);
        tick(401);
        volume = 8'd40;
        push_exp(K_GAIN, 3,   16'd100);
        push_exp(K_GAIN, 4,   16'd99);
        push_exp(K_GAIN, 239, 16'd41);
        push_exp(K_BUSY, 239, 16'h1);
        push_exp(K_GAIN, 240, 16'd40);
        push_exp(K_BUSY, 240, 16'h0);
        push_exp(K_MUTED, 240, 16'h0);
        push_exp(K_GAIN, 300, 16'd40);
        tick(300);
        sample_in = 8'h7F;
        push_exp(K_SAMPLE, 2, 16'h13);
        tick(1);
        sample_in = 8'h81;
        push_exp(K_SAMPLE, 2, 16'hEC);
        tick(1);
        sample_in = 8'hC0;
        push_exp(K_SAMPLE, 2, 16'hF6);
        drain();

        // 5: soft mute from 0x80, then re-enable on the muting clock
        do_reset();
        sample_in = 8'h7F;
        enable = 1'b1;
        volume = 8'h80;
        tick(513);
        push_exp(K_GAIN,  0, 16'h80);
        push_exp(K_BUSY,  0, 16'h0);
        push_exp(K_MUTED, 0, 16'h0);
        enable = 1'b0;
        push_exp(K_GAIN,  512, 16'h01);
        push_exp(K_BUSY,  512, 16'h1);
        push_exp(K_MUTED, 512, 16'h0);
        push_exp(K_GAIN,  513, 16'h00);
        push_exp(K_MUTED, 513, 16'h1);
        push_exp(K_BUSY,  513, 16'h0);
        tick(513);
        enable = 1'b1;
        push_exp(K_BUSY,   1, 16'h1);
        push_exp(K_MUTED,  1, 16'h0);
        push_exp(K_SAMPLE, 2, 16'h00);
        push_exp(K_SAMPLE, 3, 16'h00);
        drain();

        // 6: reset mid-ramp at gain 57
        do_reset();
        enable = 1'b1;
        volume = 8'hFF;
        tick(229);
        push_exp(K_GAIN, 0, 16'd57);
        rst_n = 1'b0;
        push_exp(K_GAIN,   1, 16'h00);
        push_exp(K_MUTED,  1, 16'h1);
        push_exp(K_BUSY,   1, 16'h0);
        push_exp(K_SAMPLE, 1, 16'h00);
        push_exp(K_PDM,    1, 16'h0);
        tick(1);
        rst_n = 1'b1;
        push_exp(K_BUSY, 1, 16'h1);
        push_exp(K_GAIN, 4, 16'h00);
        push_exp(K_GAIN, 5, 16'h01);
        drain();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
